// File: rtl/prbs_gen.sv
// Parallel PRBS word generator (PRBS7/15/23/31) with valid/ready output, seed/mode load,
// zero-seed lockup substitution, single-bit error injection and a saturating word counter.
module prbs_gen #(
    parameter int unsigned W_OUT    = 4,
    parameter logic [1:0]  DEF_MODE = 2'd2,
    parameter logic [30:0] DEF_SEED = 31'h7FFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [1:0]       mode_in,
    input  logic [30:0]      seed_in,
    input  logic             inj_err,
    output logic [W_OUT-1:0] bits_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lockup,
    output logic [31:0]      word_cnt
);

    function automatic logic [30:0] width_mask(input logic [1:0] m);
        logic [30:0] mask;
        case (m)
            2'd0:    mask = 31'h0000007F;
            2'd1:    mask = 31'h00007FFF;
            2'd2:    mask = 31'h007FFFFF;
            default: mask = 31'h7FFFFFFF;
        endcase
        return mask;
    endfunction

    function automatic logic top_bit(input logic [30:0] s, input logic [1:0] m);
        logic b;
        case (m)
            2'd0:    b = s[6];
            2'd1:    b = s[14];
            2'd2:    b = s[22];
            default: b = s[30];
        endcase
        return b;
    endfunction

    function automatic logic tap_bit(input logic [30:0] s, input logic [1:0] m);
        logic b;
        case (m)
            2'd0:    b = s[5];
            2'd1:    b = s[13];
            2'd2:    b = s[17];
            default: b = s[27];
        endcase
        return b;
    endfunction

    function automatic logic [30:0] lfsr_step(input logic [30:0] s, input logic [1:0] m);
        logic fb;
        fb = top_bit(s, m) ^ tap_bit(s, m);
        return {s[29:0], fb} & width_mask(m);
    endfunction

    // Reset state: masked default seed, with an all-zero result replaced by 1.
    localparam logic [30:0] DefMasked = DEF_SEED & width_mask(DEF_MODE);
    localparam logic        DefLockup = (DefMasked == 31'd0);
    localparam logic [30:0] DefState  = DefLockup ? 31'd1 : DefMasked;

    logic [30:0]      lfsr_r;
    logic [1:0]       mode_r;
    logic             pend_r;

    logic [30:0]      step_state;
    logic [30:0]      lfsr_nxt;
    logic [W_OUT-1:0] word_nxt;
    logic [30:0]      seed_masked;
    logic             seed_zero;
    logic             adv;
    logic             inject;
    logic             cnt_inc;

    // Unrolled W_OUT steps; bit k of the word (MSB first) is the top bit before step k.
    always_comb begin
        step_state = lfsr_r;
        word_nxt   = '0;
        for (int k = 0; k < int'(W_OUT); k++) begin
            word_nxt[W_OUT-1-k] = top_bit(step_state, mode_r);
            step_state          = lfsr_step(step_state, mode_r);
        end
        lfsr_nxt = step_state;
    end

    always_comb begin
        seed_masked = seed_in & width_mask(mode_in);
        seed_zero   = (seed_masked == 31'd0);
        adv         = en & (~out_valid | out_ready) & ~load;
        inject      = pend_r | inj_err;
        cnt_inc     = out_valid & out_ready & (word_cnt != 32'hFFFF_FFFF);
    end

    // Sequence state: load wins over advance; injection only touches the output word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r <= DefState;
            mode_r <= DEF_MODE;
            lockup <= DefLockup;
        end else if (load) begin
            lfsr_r <= seed_zero ? 31'd1 : seed_masked;
            mode_r <= mode_in;
            lockup <= seed_zero;
        end else if (adv) begin
            lfsr_r <= lfsr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits_out  <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b0;
        end else if (adv) begin
            bits_out  <= word_nxt ^ W_OUT'(inject);
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r <= 1'b0;
        end else if (adv) begin
            pend_r <= 1'b0;
        end else if (inj_err) begin
            pend_r <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= 32'd0;
        end else if (load) begin
            word_cnt <= 32'd0;
        end else if (cnt_inc) begin
            word_cnt <= word_cnt + 32'd1;
        end
    end

endmodule

// File: doc/prbs_gen.md
PRBS_GEN -- requirements
Module: prbs_gen

Interface
REQ-001 Parameter W_OUT, default 4: bits per output word, legal 1..16.
REQ-002 Parameter DEF_MODE, default 2: polynomial mode applied at reset.
REQ-003 Parameter DEF_SEED, default 31'h7FFFFF: seed applied at reset; only the active-width LSBs are used.
REQ-004 clk  in  1  single clock; all logic is rising-edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 en  in  1  request to generate words.
REQ-007 load  in  1  seed/mode load strobe.
REQ-008 mode_in  in  2  polynomial select, sampled on load: 0=PRBS7 x^7+x^6+1, 1=PRBS15 x^15+x^14+1, 2=PRBS23 x^23+x^18+1, 3=PRBS31 x^31+x^28+1.
REQ-009 seed_in  in  31  seed, sampled on load; active-width LSBs are used.
REQ-010 inj_err  in  1  single-bit error injection request.
REQ-011 bits_out  out  W_OUT  output word; the first generated bit is placed in the MSB.
REQ-012 out_valid  out  1  bits_out holds a valid word.
REQ-013 out_ready  in  1  consumer accepts the word.
REQ-014 lockup  out  1  sticky flag: a zero seed was replaced.
REQ-015 word_cnt  out  32  count of accepted words, saturating.

Function
REQ-016 State: 31-bit register lfsr_r plus mode_r; active width N = 7/15/23/31 per mode_r; bits above N-1 are held at 0.
REQ-017 One step: fb = lfsr_r[N-1] ^ lfsr_r[T-1], with T = 6/14/18/28; next state = {lfsr_r[N-2:0], fb} masked to N bits.
REQ-018 Word generation: W_OUT unrolled steps per word; output bit k (MSB first) = lfsr_r[N-1] of the state before step k.
REQ-019 Advance condition: adv = en & (~out_valid | out_ready) & ~load.
REQ-020 On adv: lfsr_r advances W_OUT steps, bits_out registers the new word, and out_valid is set the next cycle (latency 1).
REQ-021 out_valid clears when out_ready=1 and adv=0; bits_out is held stable while out_valid=1 and out_ready=0.
REQ-022 Back-to-back operation: en=1 and out_ready=1 continuously yields one word per cycle with no bubbles.
REQ-023 load has priority over adv: mode_r <= mode_in, lfsr_r <= seed_in masked, out_valid <= 0, and no word is produced that cycle.
REQ-024 Zero seed (masked seed == 0 on load or at reset): lfsr_r <= 1 and lockup <= 1.
REQ-025 lockup stays set until the next load with a nonzero masked seed.
REQ-026 inj_err is latched into pending flag pend_r; on the next adv, bit 0 (LSB) of the new word is inverted and pend_r clears.
REQ-027 inj_err coincident with adv applies to that same word; a second inj_err while pend_r=1 is absorbed (one error only).
REQ-028 Error injection never alters lfsr_r.
REQ-029 word_cnt increments on out_valid & out_ready, saturates at 32'hFFFFFFFF, and clears on load.
REQ-030 Mode change without load has no effect on the sequence.

Reset
REQ-031 Asserted reset (async): lfsr_r = DEF_SEED masked (zero-substituted per REQ-024), mode_r = DEF_MODE, bits_out = 0, out_valid = 0, pend_r = 0, word_cnt = 0, lockup = (masked DEF_SEED == 0).
REQ-032 Reset asserted mid-stream discards the pending word and any pending injection; the first word after release matches a freshly seeded sequence.

Verification
REQ-033 W_OUT=4: load mode 0 with seed 7'h7F, en=1, out_ready=1 -> words 4'hF, 4'hE, in that order.
REQ-034 W_OUT=1, PRBS7 -> the sequence repeats with period exactly 127 words and never reaches the all-zero state.
REQ-035 Defaults (PRBS23, seed 23'h7FFFFF) -> first word 4'hF; output matches a golden x^23+x^18+1 model over 10000 words.
REQ-036 out_ready held low for 3 cycles after a word is issued -> bits_out and out_valid stable for all 3 cycles; the next word follows on the cycle after out_ready rises; word_cnt increments once.
REQ-037 load with seed 0 -> lockup=1 and the sequence continues from state 1; a subsequent load with seed 5 -> lockup=0.
REQ-038 Pulse inj_err twice while en=0, then enable -> exactly one word differs from golden, in its LSB only; following words match golden.
